// File: rtl/mem_responder_pkg.sv
// Shared address/line types for the cache-to-memory path, plus the read-queue entry
// used by the memory responder.
package mem_responder_pkg;

    localparam int PADDR_W     = 32;
    localparam int LINE_BYTES  = 16;
    localparam int OFFSET_W    = $clog2(LINE_BYTES);
    localparam int CACHE_IDX_W = 6;
    localparam int CACHE_TAG_W = PADDR_W - CACHE_IDX_W - OFFSET_W;
    localparam int STAMP_W     = 32;

    typedef logic [PADDR_W-1:0]      pptr_t;
    typedef logic [LINE_BYTES*8-1:0] cacheline_t;
    typedef logic [OFFSET_W-1:0]     byte_offset_t;
    typedef logic [CACHE_IDX_W-1:0]  idx_t;
    typedef logic [CACHE_TAG_W-1:0]  tag_t;
    typedef logic [STAMP_W-1:0]      stamp_t;

    typedef struct packed {
        tag_t         tag;
        idx_t         idx;
        byte_offset_t offset;
    } paddr_fields_t;

    // rdy is the cycle stamp at which the entry may first issue
    typedef struct packed {
        pptr_t  addr;
        stamp_t rdy;
    } rd_entry_t;

    function automatic pptr_t line_align(pptr_t a);
        return {a[PADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Cache memory port: read requests, write-backs and the read-response channel.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic       req_ren;
    pptr_t      req_raddr;
    logic       req_wen;
    pptr_t      req_waddr;
    cacheline_t req_wcacheline;
    logic       rec_en;
    pptr_t      rec_addr;
    cacheline_t rec_cacheline;
    logic       busy;
    logic       overflow;

    modport master (
        output req_ren, req_raddr, req_wen, req_waddr, req_wcacheline,
        input  rec_en, rec_addr, rec_cacheline, busy, overflow
    );

    modport slave (
        input  req_ren, req_raddr, req_wen, req_waddr, req_wcacheline,
        output rec_en, rec_addr, rec_cacheline, busy, overflow
    );

endinterface

// File: rtl/mem_req_fifo.sv
// Circular buffer for pending reads; a push into a full buffer is taken when a pop
// happens on the same edge. DEPTH must be a power of two, at least 2.
module mem_req_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = buf_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: single-ported line array, in-order fixed-latency read
// responses, write-backs win the array port over read issue.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_LINES = 1024,
    parameter int LATENCY   = 5,
    parameter int QDEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave mem
);

    localparam int LINE_W  = $clog2(MEM_LINES);
    localparam int ENTRY_W = $bits(rd_entry_t);
    localparam int CNT_W   = $clog2(QDEPTH + 1);

    cacheline_t        array_q [MEM_LINES];
    stamp_t            now_q, now_d;
    rd_entry_t         push_entry, head;
    stamp_t            head_slack;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count, count_next;
    logic              head_ready, issue, accept;
    logic [LINE_W-1:0] widx, ridx;
    logic              unused_addr_bits;

    logic       rec_en_q, rec_en_d;
    pptr_t      rec_addr_q, rec_addr_d;
    cacheline_t rec_line_q, rec_line_d;
    logic       busy_q, busy_d;
    logic       overflow_q, overflow_d;

    assign widx = mem.req_waddr[OFFSET_W +: LINE_W];
    assign ridx = head.addr[OFFSET_W +: LINE_W];
    assign unused_addr_bits = ^{mem.req_waddr[PADDR_W-1:OFFSET_W+LINE_W],
                                mem.req_waddr[OFFSET_W-1:0],
                                mem.req_raddr[OFFSET_W-1:0]};

    // Signed age against the free-running stamp; issue edge is LATENCY-1 after the push edge
    assign head_slack = now_q - head.rdy;
    assign head_ready = ~fifo_empty & ~head_slack[STAMP_W-1];
    assign issue      = ~rst & head_ready & ~mem.req_wen;
    assign accept     = ~rst & mem.req_ren & (~fifo_full | issue);

    assign push_entry.addr = line_align(mem.req_raddr);
    assign push_entry.rdy  = now_q + stamp_t'(LATENCY - 1);

    mem_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (issue),
        .data_i  (push_entry),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (mem.req_wen && !rst) array_q[widx] <= mem.req_wcacheline;
    end

    always_comb begin
        now_d      = now_q + stamp_t'(1);
        rec_en_d   = issue;
        rec_addr_d = rec_addr_q;
        rec_line_d = rec_line_q;
        if (issue) begin
            rec_addr_d = head.addr;
            rec_line_d = array_q[ridx];
        end
        count_next = fifo_count + CNT_W'(accept) - CNT_W'(issue);
        // busy also covers the cycle in which the final response is presented
        busy_d     = issue | (count_next != '0);
        overflow_d = overflow_q | (mem.req_ren & ~accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            now_q      <= '0;
            rec_en_q   <= 1'b0;
            rec_addr_q <= '0;
            rec_line_q <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            now_q      <= now_d;
            rec_en_q   <= rec_en_d;
            rec_addr_q <= rec_addr_d;
            rec_line_q <= rec_line_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign mem.rec_en        = rec_en_q;
    assign mem.rec_addr      = rec_addr_q;
    assign mem.rec_cacheline = rec_line_q;
    assign mem.busy          = busy_q;
    assign mem.overflow      = overflow_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a cycle table for the LATENCY=5 instance, then
// hand sequences for queue overflow (LATENCY=8) and reset flush.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int NV = 47;

    typedef struct {
        logic       ren;
        pptr_t      raddr;
        logic       wen;
        pptr_t      waddr;
        cacheline_t wdata;
        logic       exp_en;
        pptr_t      exp_addr;
        cacheline_t exp_data;
        logic       exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vt [NV];

    mem_responder_if if0 ();
    mem_responder_if if8 ();

    mem_responder #(.MEM_LINES(1024), .LATENCY(5), .QDEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .mem (if0)
    );

    mem_responder #(.MEM_LINES(1024), .LATENCY(8), .QDEPTH(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .mem (if8)
    );

    always #5 clk = ~clk;

    function automatic cacheline_t fill(logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic set_w(input int t, input pptr_t a, input cacheline_t d);
        vt[t].wen   = 1'b1;
        vt[t].waddr = a;
        vt[t].wdata = d;
    endtask

    task automatic set_r(input int t, input pptr_t a);
        vt[t].ren   = 1'b1;
        vt[t].raddr = a;
    endtask

    task automatic set_rsp(input int t, input pptr_t a, input cacheline_t d);
        vt[t].exp_en   = 1'b1;
        vt[t].exp_addr = a;
        vt[t].exp_data = d;
    endtask

    task automatic set_busy(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) vt[i].exp_busy = 1'b1;
    endtask

    task automatic drive0(input logic ren, input pptr_t ra, input logic wen,
                          input pptr_t wa, input cacheline_t wd);
        if0.req_ren        = ren;
        if0.req_raddr      = ra;
        if0.req_wen        = wen;
        if0.req_waddr      = wa;
        if0.req_wcacheline = wd;
    endtask

    initial begin
        drive0(1'b0, '0, 1'b0, '0, '0);
        if8.req_ren        = 1'b0;
        if8.req_raddr      = '0;
        if8.req_wen        = 1'b0;
        if8.req_waddr      = '0;
        if8.req_wcacheline = '0;

        for (int i = 0; i < NV; i++) begin
            vt[i].ren = 1'b0;    vt[i].raddr = '0;
            vt[i].wen = 1'b0;    vt[i].waddr = '0;    vt[i].wdata = '0;
            vt[i].exp_en = 1'b0; vt[i].exp_addr = '0; vt[i].exp_data = '0;
            vt[i].exp_busy = 1'b0;
        end
        // preload lines, then write-then-read and a mid-line read address
        set_w(0, 32'h10, fill(8'hD1));
        set_w(1, 32'h20, fill(8'hD2));
        set_w(2, 32'h30, fill(8'hD3));
        set_w(3, 32'h40, fill(8'hD4));
        set_w(4, 32'h1000, fill(8'hA5));
        set_r(5, 32'h1000);
        set_r(6, 32'h1004);
        set_rsp(10, 32'h1000, fill(8'hA5));
        set_rsp(11, 32'h1000, fill(8'hA5));
        set_busy(6, 11);
        // back-to-back reads give back-to-back responses
        set_r(13, 32'h10); set_r(14, 32'h20); set_r(15, 32'h30); set_r(16, 32'h40);
        set_rsp(18, 32'h10, fill(8'hD1));
        set_rsp(19, 32'h20, fill(8'hD2));
        set_rsp(20, 32'h30, fill(8'hD3));
        set_rsp(21, 32'h40, fill(8'hD4));
        set_busy(14, 21);
        // two writes at the issue edge slip the response by two; second write just visible
        set_r(23, 32'h20);
        set_w(27, 32'h20, fill(8'h5A));
        set_w(28, 32'h20, fill(8'h6B));
        set_rsp(30, 32'h20, fill(8'h6B));
        set_busy(24, 30);
        // simultaneous read and write of one line
        set_r(32, 32'h40);
        set_w(32, 32'h40, fill(8'hC3));
        set_rsp(37, 32'h40, fill(8'hC3));
        set_busy(33, 37);
        // tag bits above the line index alias onto the same line
        set_w(38, 32'h4010, fill(8'hE7));
        set_r(39, 32'h10);
        set_r(40, 32'h4010);
        set_rsp(44, 32'h10, fill(8'hE7));
        set_rsp(45, 32'h4010, fill(8'hE7));
        set_busy(40, 45);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset rec_en", 128'(if0.rec_en), 128'(0));
        chk("reset busy", 128'(if0.busy), 128'(0));
        chk("reset overflow", 128'(if0.overflow), 128'(0));
        chk("reset8 rec_en", 128'(if8.rec_en), 128'(0));
        chk("reset8 overflow", 128'(if8.overflow), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("t%0d rec_en", i), 128'(if0.rec_en), 128'(vt[i].exp_en));
            if (vt[i].exp_en) begin
                chk($sformatf("t%0d rec_addr", i), 128'(if0.rec_addr), 128'(vt[i].exp_addr));
                chk($sformatf("t%0d rec_data", i), if0.rec_cacheline, vt[i].exp_data);
            end
            chk($sformatf("t%0d busy", i), 128'(if0.busy), 128'(vt[i].exp_busy));
            chk($sformatf("t%0d overflow", i), 128'(if0.overflow), 128'(0));
            drive0(vt[i].ren, vt[i].raddr, vt[i].wen, vt[i].waddr, vt[i].wdata);
        end

        // LATENCY=8: fifth consecutive read finds the queue full with no pop
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk($sformatf("ovf k%0d rec_en", k), 128'(if8.rec_en), 128'(k >= 8 && k <= 11));
            if (k >= 8 && k <= 11)
                chk($sformatf("ovf k%0d rec_addr", k), 128'(if8.rec_addr),
                    128'(pptr_t'(32'h100 * (k - 7))));
            chk($sformatf("ovf k%0d overflow", k), 128'(if8.overflow), 128'(k >= 5));
            if8.req_ren   = (k < 5);
            if8.req_raddr = pptr_t'(32'h100 * (k + 1));
        end
        if8.req_ren = 1'b0;

        // reset with reads in flight: flush, clear sticky flag, array survives
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                chk("rst k3 busy before", 128'(if0.busy), 128'(1));
                chk("rst k3 overflow8 before", 128'(if8.overflow), 128'(1));
            end
            if (k >= 4 && k <= 12) begin
                chk($sformatf("rst k%0d rec_en", k), 128'(if0.rec_en), 128'(0));
                chk($sformatf("rst k%0d busy", k), 128'(if0.busy), 128'(0));
                chk($sformatf("rst k%0d overflow8", k), 128'(if8.overflow), 128'(0));
                chk($sformatf("rst k%0d busy8", k), 128'(if8.busy), 128'(0));
            end
            if (k >= 13) begin
                chk($sformatf("rst k%0d rec_en", k), 128'(if0.rec_en), 128'(k == 18));
                if (k == 18) begin
                    chk("rst k18 rec_addr", 128'(if0.rec_addr), 128'(32'h700));
                    chk("rst k18 rec_data", if0.rec_cacheline, fill(8'h3C));
                end
            end
            rst = (k == 3);
            case (k)
                0:       drive0(1'b0, '0, 1'b1, 32'h700, fill(8'h3C));
                1:       drive0(1'b1, 32'h100, 1'b0, '0, '0);
                2:       drive0(1'b1, 32'h200, 1'b0, '0, '0);
                3:       drive0(1'b1, 32'h300, 1'b0, '0, '0);
                13:      drive0(1'b1, 32'h700, 1'b0, '0, '0);
                default: drive0(1'b0, '0, 1'b0, '0, '0);
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
